// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and response-stage state for the shared ALU
package alu_pkg;

   localparam int WIDTH    = 32;
   localparam int OP_WIDTH = 5;

   localparam logic [OP_WIDTH-1:0] OP_ADD = 5'b00001;
   localparam logic [OP_WIDTH-1:0] OP_SUB = 5'b10001;
   localparam logic [OP_WIDTH-1:0] OP_XOR = 5'b01001;
   localparam logic [OP_WIDTH-1:0] OP_OR  = 5'b01101;
   localparam logic [OP_WIDTH-1:0] OP_AND = 5'b01111;
   localparam logic [OP_WIDTH-1:0] OP_SLL = 5'b00011;
   localparam logic [OP_WIDTH-1:0] OP_SLT = 5'b00101;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

   function automatic logic is_legal_op(input logic [OP_WIDTH-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SLT: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two requester ports plus the registered response port
interface alu_arbiter_if;
   import alu_pkg::*;

   logic                req0_valid;
   logic                req0_ready;
   logic [OP_WIDTH-1:0] req0_op;
   logic [WIDTH-1:0]    req0_a;
   logic [WIDTH-1:0]    req0_b;

   logic                req1_valid;
   logic                req1_ready;
   logic [OP_WIDTH-1:0] req1_op;
   logic [WIDTH-1:0]    req1_a;
   logic [WIDTH-1:0]    req1_b;

   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_id;
   logic [WIDTH-1:0]    rsp_result;
   logic                rsp_err;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_err
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_err
   );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU; unknown opcodes produce zero
module alu
   import alu_pkg::*;
(
   output logic [WIDTH-1:0]    out,
   input  logic [OP_WIDTH-1:0] opcode,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b
);

   logic slt;

   always_comb begin
      slt = ($signed(a) < $signed(b));
      out = '0;
      case (opcode)
         OP_ADD:  out = a + b;
         OP_SUB:  out = a - b;
         OP_XOR:  out = a ^ b;
         OP_OR:   out = a | b;
         OP_AND:  out = a & b;
         OP_SLL:  out = a << b[4:0];
         OP_SLT:  out = {{(WIDTH-1){1'b0}}, slt};
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of one ALU between two requesters,
// result held in a one-entry response register tagged with the requester id
module alu_arbiter
   import alu_pkg::*;
(
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);

   rsp_state_t          state_q;
   rsp_state_t          state_d;
   logic                rr_ptr;
   logic                can_accept;
   logic                gnt_valid;
   logic                gnt_id;
   logic [OP_WIDTH-1:0] mux_op;
   logic [WIDTH-1:0]    mux_a;
   logic [WIDTH-1:0]    mux_b;
   logic [WIDTH-1:0]    alu_out;
   logic                legal;
   logic                rsp_id_q;
   logic [WIDTH-1:0]    rsp_result_q;
   logic                rsp_err_q;

   // A full stage may still accept when it drains in the same cycle.
   always_comb begin
      can_accept = (state_q == RSP_EMPTY) || bus.rsp_ready;
      gnt_valid  = can_accept && (bus.req0_valid || bus.req1_valid);
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_id = rr_ptr;
      end else begin
         gnt_id = bus.req1_valid;
      end
   end

   always_comb begin
      mux_op = gnt_id ? bus.req1_op : bus.req0_op;
      mux_a  = gnt_id ? bus.req1_a  : bus.req0_a;
      mux_b  = gnt_id ? bus.req1_b  : bus.req0_b;
      legal  = is_legal_op(mux_op);
   end

   alu u_alu (
      .out    (alu_out),
      .opcode (mux_op),
      .a      (mux_a),
      .b      (mux_b)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         RSP_EMPTY: if (gnt_valid) state_d = RSP_FULL;
         RSP_FULL:  if (bus.rsp_ready && !gnt_valid) state_d = RSP_EMPTY;
         default:   state_d = RSP_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RSP_EMPTY;
         rr_ptr       <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (gnt_valid) begin
            rr_ptr       <= ~gnt_id;
            rsp_id_q     <= gnt_id;
            rsp_result_q <= legal ? alu_out : '0;
            rsp_err_q    <= ~legal;
         end
      end
   end

   assign bus.req0_ready = gnt_valid && !gnt_id;
   assign bus.req1_ready = gnt_valid && gnt_id;
   assign bus.rsp_valid  = (state_q == RSP_FULL);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vectors with a response scoreboard for alu_arbiter
module tb_alu_arbiter;
   import alu_pkg::*;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t q[$];
   exp_t e0;
   exp_t e1;
   exp_t me;
   logic r0;
   logic r1;

   alu_arbiter_if bus ();

   alu_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic set0(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic err);
      bus.req0_valid = v;
      bus.req0_op    = op;
      bus.req0_a     = a;
      bus.req0_b     = b;
      e0.id  = 1'b0;
      e0.res = res;
      e0.err = err;
   endtask

   task automatic set1(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic err);
      bus.req1_valid = v;
      bus.req1_op    = op;
      bus.req1_a     = a;
      bus.req1_b     = b;
      e1.id  = 1'b1;
      e1.res = res;
      e1.err = err;
   endtask

   // One clock: sample readys on the falling edge, record accepted ops, return just after the rising edge.
   task automatic cyc(output logic g0, output logic g1);
      @(negedge clk);
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      if (g0) q.push_back(e0);
      if (g1) q.push_back(e1);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got id=%0d result=%h err=%b, want no response",
                     bus.rsp_id, bus.rsp_result, bus.rsp_err);
         end else begin
            me = q.pop_front();
            chkb("rsp_id", bus.rsp_id, me.id);
            chk("rsp_result", bus.rsp_result, me.res);
            chkb("rsp_err", bus.rsp_err, me.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [4:0]  v_op  [5] = '{OP_SLT, OP_SLL, OP_ADD, OP_AND, OP_SLT};
   logic [31:0] v_a   [5] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0000F0F0, 32'h1};
   logic [31:0] v_b   [5] = '{32'h1, 32'h21, 32'h1, 32'h0000FF00, 32'hFFFFFFFF};
   logic [31:0] v_res [5] = '{32'h1, 32'h2, 32'h0, 32'h0000F000, 32'h0};

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.rsp_ready = 1'b0;
      set0(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      set1(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      chkb("reset_rsp_valid", bus.rsp_valid, 1'b0);
      chkb("reset_rsp_id", bus.rsp_id, 1'b0);
      chk("reset_rsp_result", bus.rsp_result, 32'h0);
      chkb("reset_rsp_err", bus.rsp_err, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.rsp_ready = 1'b1;

      // single requester, latency one
      set0(1'b1, OP_ADD, 32'h5, 32'h3, 32'h8, 1'b0);
      cyc(r0, r1);
      chkb("t1_ready0", r0, 1'b1);
      chkb("t1_ready1", r1, 1'b0);
      set0(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      chkb("t1_rsp_valid", bus.rsp_valid, 1'b1);
      cyc(r0, r1);
      chkb("t1_drain", bus.rsp_valid, 1'b0);

      // both valid straight after reset: strict alternation starting with 0
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      set0(1'b1, OP_SUB, 32'h10, 32'h1, 32'h0000000F, 1'b0);
      set1(1'b1, OP_XOR, 32'hFF, 32'h0F, 32'h000000F0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(r0, r1);
         chkb("t2_alt_ready0", r0, (i % 2) == 0);
         chkb("t2_alt_ready1", r1, (i % 2) == 1);
      end
      set0(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      set1(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cyc(r0, r1);
      chkb("t2_drain", bus.rsp_valid, 1'b0);

      // backpressure holds the response and blocks grants
      bus.rsp_ready = 1'b0;
      set0(1'b1, OP_ADD, 32'h1, 32'h2, 32'h3, 1'b0);
      cyc(r0, r1);
      chkb("t3_first_grant", r0, 1'b1);
      set0(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      set1(1'b1, OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(r0, r1);
         chkb("t3_hold_ready0", r0, 1'b0);
         chkb("t3_hold_ready1", r1, 1'b0);
         chkb("t3_hold_valid", bus.rsp_valid, 1'b1);
         chkb("t3_hold_id", bus.rsp_id, 1'b0);
         chk("t3_hold_result", bus.rsp_result, 32'h3);
         chkb("t3_hold_err", bus.rsp_err, 1'b0);
      end
      bus.rsp_ready = 1'b1;
      cyc(r0, r1);
      chkb("t3_release_ready1", r1, 1'b1);
      chkb("t3_release_ready0", r0, 1'b0);
      set1(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cyc(r0, r1);
      chkb("t3_drain", bus.rsp_valid, 1'b0);

      // arithmetic edge cases, back to back on requester 0
      for (int i = 0; i < 5; i++) begin
         set0(1'b1, v_op[i], v_a[i], v_b[i], v_res[i], 1'b0);
         cyc(r0, r1);
         chkb("t4_ready0", r0, 1'b1);
      end
      set0(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cyc(r0, r1);

      // illegal opcode flags the response, next legal op clears it
      set1(1'b1, 5'b11111, 32'h5, 32'h3, 32'h0, 1'b1);
      cyc(r0, r1);
      chkb("t5_ready1", r1, 1'b1);
      chkb("t5_err_set", bus.rsp_err, 1'b1);
      chkb("t5_err_id", bus.rsp_id, 1'b1);
      set1(1'b1, OP_ADD, 32'h2, 32'h2, 32'h4, 1'b0);
      cyc(r0, r1);
      chkb("t5_ready1_legal", r1, 1'b1);
      chkb("t5_err_clear", bus.rsp_err, 1'b0);
      set1(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cyc(r0, r1);

      // reset while a response is held drops it; requester 0 wins afterwards
      bus.rsp_ready = 1'b0;
      set0(1'b1, OP_ADD, 32'h7, 32'h1, 32'h8, 1'b0);
      set1(1'b1, OP_SUB, 32'h9, 32'h4, 32'h5, 1'b0);
      cyc(r0, r1);
      chkb("t6_pre_ready0", r0, 1'b1);
      chkb("t6_pre_valid", bus.rsp_valid, 1'b1);
      rst = 1'b1;
      #1;
      chkb("t6_async_drop", bus.rsp_valid, 1'b0);
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      cyc(r0, r1);
      chkb("t6_after_ready0", r0, 1'b1);
      chkb("t6_after_ready1", r1, 1'b0);
      set0(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cyc(r0, r1);
      chkb("t6_next_ready1", r1, 1'b1);
      set1(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cyc(r0, r1);
      chkb("t6_drain", bus.rsp_valid, 1'b0);

      chk("scoreboard_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
